// File: rtl/ysyx_23060061_clint_if.sv
// AXI-Lite bus bundle between the LSU (master) and the CLINT timer (slave).
interface ysyx_23060061_clint_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/ysyx_23060061_clint.sv
// Core-local timer (mtime/mtimecmp, mtip) behind an AXI-Lite responder.
// Optional YSYX_23060061_CLINT_SNAPSHOT_EN: reading mtime lo latches mtime hi for a tear-free hi read.
module ysyx_23060061_clint #(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int unsigned DIV       = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  ysyx_23060061_clint_if.slave         bus,
  output logic                         mtip
);

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [31:0] DIV_M1      = 32'(DIV - 1);

  typedef enum logic {R_IDLE, R_RESP} rstate_e;
  typedef enum logic {W_IDLE, W_RESP} wstate_e;

  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic [31:0] r_presc;
  logic        r_mtip;

  rstate_e     r_rstate;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp;

  wstate_e     r_wstate;
  logic        r_aw_held;
  logic        r_w_held;
  logic [31:0] r_awaddr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [1:0]  r_bresp;

`ifdef YSYX_23060061_CLINT_SNAPSHOT_EN
  logic [31:0] r_shadow;
`endif

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

  logic        w_ar_hs;
  logic        w_r_hs;
  logic        w_aw_hs;
  logic        w_w_hs;
  logic        w_b_hs;
  logic [31:0] w_ar_off;
  logic        w_ar_hit;
  logic [31:0] w_rd_val;
  logic [31:0] w_wr_addr;
  logic [31:0] w_wr_data;
  logic [3:0]  w_wr_strb;
  logic [31:0] w_wr_off;
  logic        w_wr_hit;
  logic        w_wr_apply;
  logic        w_mtime_wr;
  logic        w_cmp_wr;
  logic        w_tick;

  assign bus.arready = (r_rstate == R_IDLE);
  assign bus.rvalid  = (r_rstate == R_RESP);
  assign bus.rdata   = r_rdata;
  assign bus.rresp   = r_rresp;
  assign bus.awready = (r_wstate == W_IDLE) && !r_aw_held;
  assign bus.wready  = (r_wstate == W_IDLE) && !r_w_held;
  assign bus.bvalid  = (r_wstate == W_RESP);
  assign bus.bresp   = r_bresp;
  assign mtip        = r_mtip;

  assign w_ar_hs = bus.arvalid && bus.arready;
  assign w_r_hs  = bus.rvalid  && bus.rready;
  assign w_aw_hs = bus.awvalid && bus.awready;
  assign w_w_hs  = bus.wvalid  && bus.wready;
  assign w_b_hs  = bus.bvalid  && bus.bready;

  // Unsigned offset: addresses below BASE_ADDR wrap to huge values and miss the window.
  assign w_ar_off = bus.araddr - BASE_ADDR;
  assign w_ar_hit = (w_ar_off < 32'd16);

  always_comb begin
    w_rd_val = 32'd0;
    case (w_ar_off[3:2])
      2'd0: w_rd_val = r_mtime[31:0];
`ifdef YSYX_23060061_CLINT_SNAPSHOT_EN
      2'd1: w_rd_val = r_shadow;
`else
      2'd1: w_rd_val = r_mtime[63:32];
`endif
      2'd2: w_rd_val = r_mtimecmp[31:0];
      2'd3: w_rd_val = r_mtimecmp[63:32];
      default: w_rd_val = 32'd0;
    endcase
  end

  // A write applies on the edge where the later of AW/W is present, using held or live beats.
  assign w_wr_addr  = r_aw_held ? r_awaddr : bus.awaddr;
  assign w_wr_data  = r_w_held  ? r_wdata  : bus.wdata;
  assign w_wr_strb  = r_w_held  ? r_wstrb  : bus.wstrb;
  assign w_wr_off   = w_wr_addr - BASE_ADDR;
  assign w_wr_hit   = (w_wr_off < 32'd16);
  assign w_wr_apply = (r_wstate == W_IDLE) && (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
  assign w_mtime_wr = w_wr_apply && w_wr_hit && !w_wr_off[3];
  assign w_cmp_wr   = w_wr_apply && w_wr_hit &&  w_wr_off[3];
  assign w_tick     = (r_presc == DIV_M1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mtime    <= 64'd0;
      r_mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
      r_presc    <= 32'd0;
      r_mtip     <= 1'b0;
    end else begin
      r_mtip <= (r_mtime >= r_mtimecmp);
      // Software writes to mtime win over the increment and restart the prescaler.
      if (w_mtime_wr) begin
        r_presc <= 32'd0;
        if (w_wr_off[2]) r_mtime[63:32] <= merge_bytes(r_mtime[63:32], w_wr_data, w_wr_strb);
        else             r_mtime[31:0]  <= merge_bytes(r_mtime[31:0],  w_wr_data, w_wr_strb);
      end else if (w_tick) begin
        r_presc <= 32'd0;
        r_mtime <= r_mtime + 64'd1;
      end else begin
        r_presc <= r_presc + 32'd1;
      end
      if (w_cmp_wr) begin
        if (w_wr_off[2]) r_mtimecmp[63:32] <= merge_bytes(r_mtimecmp[63:32], w_wr_data, w_wr_strb);
        else             r_mtimecmp[31:0]  <= merge_bytes(r_mtimecmp[31:0],  w_wr_data, w_wr_strb);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rstate <= R_IDLE;
      r_rdata  <= 32'd0;
      r_rresp  <= RESP_OKAY;
`ifdef YSYX_23060061_CLINT_SNAPSHOT_EN
      r_shadow <= 32'd0;
`endif
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (w_ar_hs) begin
            r_rdata  <= w_ar_hit ? w_rd_val : 32'd0;
            r_rresp  <= w_ar_hit ? RESP_OKAY : RESP_SLVERR;
            r_rstate <= R_RESP;
`ifdef YSYX_23060061_CLINT_SNAPSHOT_EN
            if (w_ar_hit && (w_ar_off[3:2] == 2'd0)) r_shadow <= r_mtime[63:32];
`endif
          end
        end
        R_RESP: begin
          if (w_r_hs) r_rstate <= R_IDLE;
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wstate  <= W_IDLE;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_wr_apply) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_bresp   <= w_wr_hit ? RESP_OKAY : RESP_SLVERR;
            r_wstate  <= W_RESP;
          end else begin
            if (w_aw_hs) r_aw_held <= 1'b1;
            if (w_w_hs)  r_w_held  <= 1'b1;
          end
        end
        W_RESP: begin
          if (w_b_hs) r_wstate <= W_IDLE;
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // Beat payload registers carry no reset; they are only consumed when the held flags are set.
  always_ff @(posedge clk) begin
    if (w_aw_hs) r_awaddr <= bus.awaddr;
    if (w_w_hs) begin
      r_wdata <= bus.wdata;
      r_wstrb <= bus.wstrb;
    end
  end

endmodule

// File: tb/tb_ysyx_23060061_clint.sv
// Randomised bench for the CLINT timer with a cycle-level behavioural model of the register file and bus.
module tb_ysyx_23060061_clint;
  localparam logic [31:0] BASE = 32'h0200_0000;
  localparam int unsigned DIV  = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mtip;

  ysyx_23060061_clint_if bus();

  ysyx_23060061_clint #(.BASE_ADDR(BASE), .DIV(DIV)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .mtip (mtip)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: mtime is a closed form base + elapsed_edges/DIV, re-based on reset or software writes.
  longint unsigned n_edges = 0;
  logic        model_on = 1'b0;
  logic [63:0] m_base, m_cmp;
  longint unsigned m_t0;
  logic        m_mtip, m_rvalid, m_bvalid, m_aw_held, m_w_held;
  logic [31:0] m_rdata, m_shadow, m_awaddr, m_wdata;
  logic [1:0]  m_rresp, m_bresp;
  logic [3:0]  m_wstrb;

  function automatic logic [31:0] merge32(input logic [31:0] o, input logic [31:0] d,
                                          input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [63:0] mtime_at(input longint unsigned ed);
    return m_base + 64'((ed - m_t0) / DIV);
  endfunction

  task automatic model_step();
    logic [63:0] cur;
    logic        ar_hs, r_hs, aw_hs, w_hs, apply, hit;
    logic [31:0] wa, wd, off, rv;
    logic [3:0]  ws;
    if (model_on) begin
      check("arready", bus.arready, !m_rvalid);
      check("rvalid",  bus.rvalid,  m_rvalid);
      check("rdata",   bus.rdata,   m_rdata);
      check("rresp",   bus.rresp,   m_rresp);
      check("awready", bus.awready, !m_bvalid && !m_aw_held);
      check("wready",  bus.wready,  !m_bvalid && !m_w_held);
      check("bvalid",  bus.bvalid,  m_bvalid);
      check("bresp",   bus.bresp,   m_bresp);
      check("mtip",    mtip,        m_mtip);
    end
    if (rst) begin
      m_base = 64'd0; m_t0 = n_edges + 1; m_cmp = '1; m_mtip = 1'b0; m_shadow = 32'd0;
      m_rvalid = 1'b0; m_rdata = 32'd0; m_rresp = 2'd0;
      m_bvalid = 1'b0; m_bresp = 2'd0; m_aw_held = 1'b0; m_w_held = 1'b0;
      model_on = 1'b1;
    end else if (model_on) begin
      cur   = mtime_at(n_edges);
      ar_hs = bus.arvalid && !m_rvalid;
      r_hs  = m_rvalid && bus.rready;
      aw_hs = bus.awvalid && !m_bvalid && !m_aw_held;
      w_hs  = bus.wvalid  && !m_bvalid && !m_w_held;
      apply = !m_bvalid && (m_aw_held || aw_hs) && (m_w_held || w_hs);
      wa = m_aw_held ? m_awaddr : bus.awaddr;
      wd = m_w_held  ? m_wdata  : bus.wdata;
      ws = m_w_held  ? m_wstrb  : bus.wstrb;
      m_mtip = (cur >= m_cmp);
      if (ar_hs) begin
        off = bus.araddr - BASE;
        hit = (off < 32'd16);
        case (off[3:2])
          2'd0: rv = cur[31:0];
`ifdef YSYX_23060061_CLINT_SNAPSHOT_EN
          2'd1: rv = m_shadow;
`else
          2'd1: rv = cur[63:32];
`endif
          2'd2: rv = m_cmp[31:0];
          default: rv = m_cmp[63:32];
        endcase
        m_rdata  = hit ? rv : 32'd0;
        m_rresp  = hit ? 2'b00 : 2'b10;
        m_rvalid = 1'b1;
        if (hit && off[3:2] == 2'd0) m_shadow = cur[63:32];
      end else if (r_hs) begin
        m_rvalid = 1'b0;
      end
      if (apply) begin
        off = wa - BASE;
        hit = (off < 32'd16);
        if (hit) begin
          case (off[3:2])
            2'd0: begin m_base = {cur[63:32], merge32(cur[31:0], wd, ws)}; m_t0 = n_edges + 1; end
            2'd1: begin m_base = {merge32(cur[63:32], wd, ws), cur[31:0]}; m_t0 = n_edges + 1; end
            2'd2: m_cmp = {m_cmp[63:32], merge32(m_cmp[31:0], wd, ws)};
            default: m_cmp = {merge32(m_cmp[63:32], wd, ws), m_cmp[31:0]};
          endcase
        end
        m_bvalid = 1'b1; m_bresp = hit ? 2'b00 : 2'b10;
        m_aw_held = 1'b0; m_w_held = 1'b0;
      end else begin
        if (aw_hs) begin m_aw_held = 1'b1; m_awaddr = bus.awaddr; end
        if (w_hs)  begin m_w_held = 1'b1; m_wdata = bus.wdata; m_wstrb = bus.wstrb; end
        if (m_bvalid && bus.bready) m_bvalid = 1'b0;
      end
    end
    n_edges++;
  endtask

  initial forever begin
    @(negedge clk);
    model_step();
  end

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
    int n;
    logic hs;
    bus.araddr = a; bus.arvalid = 1'b1; n = 0;
    do begin hs = bus.arready; @(posedge clk); #1; n++; end while (!hs && n < 50);
    bus.arvalid = 1'b0;
    check("ar_handshake_done", hs, 1'b1);
    n = 0;
    while (!bus.rvalid && n < 50) begin @(posedge clk); #1; n++; end
    check("rvalid_arrived", bus.rvalid, 1'b1);
    d = bus.rdata; r = bus.rresp;
    n = 0;
    do begin hs = bus.rready; @(posedge clk); #1; n++; end while (!hs && n < 50);
  endtask

  // mode 0: AW and W together, 1: AW one cycle before W, 2: W before AW
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int mode, output logic [1:0] r);
    int n;
    logic aw_hs, w_hs, hs;
    bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
    bus.awvalid = (mode != 2); bus.wvalid = (mode != 1); n = 0;
    while ((bus.awvalid || bus.wvalid) && n < 50) begin
      aw_hs = bus.awvalid && bus.awready;
      w_hs  = bus.wvalid && bus.wready;
      @(posedge clk); #1; n++;
      if (aw_hs) bus.awvalid = 1'b0;
      if (w_hs)  bus.wvalid  = 1'b0;
      if (aw_hs && mode == 1) bus.wvalid  = 1'b1;
      if (w_hs  && mode == 2) bus.awvalid = 1'b1;
    end
    check("aw_w_handshake_done", bus.awvalid || bus.wvalid, 1'b0);
    n = 0;
    while (!bus.bvalid && n < 50) begin @(posedge clk); #1; n++; end
    check("bvalid_arrived", bus.bvalid, 1'b1);
    r = bus.bresp;
    n = 0;
    do begin hs = bus.bready; @(posedge clk); #1; n++; end while (!hs && n < 50);
  endtask

  function automatic logic [31:0] pick_addr();
    int unsigned k;
    k = $urandom_range(0, 9);
    if (k < 8) return BASE + 32'((k % 4) * 4) + 32'($urandom_range(0, 3));
    if (k == 8) return BASE + 32'd16 + 32'($urandom_range(0, 64));
    return BASE - 32'd4;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int k;
    bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b1;
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
    bus.wvalid = 1'b0; bus.bready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_mtip", mtip, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    do_read(BASE, d, r);
    check("idle_mtime_lo", d, 32'd10);
    check("idle_rresp", r, 2'b00);
    check("idle_mtip", mtip, 1'b0);

    do_write(BASE + 32'h8, 32'd5, 4'hF, 1, r);
    check("cmp_lo_bresp", r, 2'b00);
    do_write(BASE + 32'hC, 32'd0, 4'hF, 2, r);
    do_write(BASE + 32'h0, 32'd0, 4'hF, 0, r);
    check("mtip_low_after_mtime_clear", mtip, 1'b0);
    k = 0;
    while (!mtip && k < 20) begin @(posedge clk); #1; k++; end
    check("mtip_rise_delay", k, 5);

    do_write(BASE + 32'h4, 32'hFFFF_FFFF, 4'hF, 0, r);
    do_write(BASE + 32'h0, 32'hFFFF_FFFF, 4'hF, 0, r);
    @(posedge clk); #1;
    do_read(BASE, d, r);
    check("wrap_lo", d, 32'd1);
    do_read(BASE + 32'h4, d, r);
    check("wrap_hi", d, 32'd0);

    do_write(BASE + 32'h4, 32'd0, 4'hF, 0, r);
    do_write(BASE + 32'h0, 32'hFFFF_FFFE, 4'hF, 0, r);
    do_read(BASE, d, r);
    check("carry_lo", d, 32'hFFFF_FFFF);
    do_read(BASE + 32'h4, d, r);
`ifdef YSYX_23060061_CLINT_SNAPSHOT_EN
    check("carry_hi_shadow", d, 32'd0);
`else
    check("carry_hi_live", d, 32'd1);
`endif

    do_write(BASE + 32'h8, 32'h0000_AB00, 4'b0010, 0, r);
    do_read(BASE + 32'h8, d, r);
    check("partial_cmp_lo", d, 32'h0000_AB05);
    do_read(BASE + 32'hC, d, r);
    check("partial_cmp_hi", d, 32'd0);

    do_read(BASE + 32'h10, d, r);
    check("oor_rdata", d, 32'd0);
    check("oor_rresp", r, 2'b10);
    do_read(BASE - 32'd4, d, r);
    check("below_rresp", r, 2'b10);
    do_write(32'h0100_0000, 32'h1234_5678, 4'hF, 0, r);
    check("oor_bresp", r, 2'b10);
    do_read(BASE + 32'h8, d, r);
    check("oor_no_change", d, 32'h0000_AB05);

    bus.rready = 1'b0; bus.araddr = BASE + 32'h8; bus.arvalid = 1'b1;
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall_rvalid", bus.rvalid, 1'b1);
      check("stall_rdata", bus.rdata, 32'h0000_AB05);
      @(posedge clk); #1;
    end
    bus.rready = 1'b1;
    @(posedge clk); #1;
    check("stall_release", bus.rvalid, 1'b0);

    bus.bready = 1'b0; bus.awaddr = BASE + 32'h8; bus.wdata = 32'd7; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    @(posedge clk); #1;
    check("bresp_held_bvalid", bus.bvalid, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bus.bready = 1'b1;
    check("rst_drops_bvalid", bus.bvalid, 1'b0);
    check("rst_awready", bus.awready, 1'b1);
    do_read(BASE + 32'h8, d, r);
    check("rst_cmp_lo", d, 32'hFFFF_FFFF);

    for (int i = 0; i < 300; i++) begin
      logic [31:0] ra, wa, wd, rd;
      logic [1:0]  rr, br;
      logic [3:0]  ws;
      int op, md;
      op = $urandom_range(0, 2); md = $urandom_range(0, 2);
      ra = pick_addr(); wa = pick_addr(); wd = $urandom; ws = 4'($urandom_range(0, 15));
      rr = 2'b00; br = 2'b00; rd = 32'd0;
      case (op)
        0: do_read(ra, rd, rr);
        1: do_write(wa, wd, ws, md, br);
        default: fork
          do_read(ra, rd, rr);
          do_write(wa, wd, ws, md, br);
        join
      endcase
      if (op != 1) begin
        check("rnd_rresp", rr, ((ra - BASE) < 32'd16) ? 2'b00 : 2'b10);
        if ((ra - BASE) >= 32'd16) check("rnd_err_rdata", rd, 32'd0);
      end
      if (op != 0) check("rnd_bresp", br, ((wa - BASE) < 32'd16) ? 2'b00 : 2'b10);
      k = $urandom_range(0, 2);
      repeat (k) begin @(posedge clk); #1; end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
